// File: rtl/slc_mem_pkg.sv
// slc_mem_pkg: shared types for the SLC-3 SRAM sequencer.
// Sequencer states, strobe levels and the lane-count helper.
package slc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic STB_OFF = 1'b1;
  localparam logic STB_ON  = 1'b0;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-state down-counter and ready timeout counter.
// In: clk, rst_n, load, tick, ready. Out: done, timed_out.
module mem_wait_timer
  import slc_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  input  logic ready,
  output logic done,
  output logic timed_out
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]    wcnt;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      tcnt <= '0;
    end else if (load) begin
      wcnt <= 4'(WAIT_CYCLES);
      tcnt <= '0;
    end else if (tick) begin
      if (wcnt != '0)
        wcnt <= wcnt - 4'd1;
      else if (!ready && tcnt != '1)
        tcnt <= tcnt + TW'(1);
    end
  end

  assign done = (wcnt == '0);

  generate
    if (TIMEOUT > 0) begin : g_to
      assign timed_out = done && (tcnt == TW'(TIMEOUT));
    end else begin : g_no_to
      assign timed_out = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/slc_mem_ctrl.sv
// slc_mem_ctrl: req/ack to SRAM cycle sequencer (CE/OE/WE/BE, active-low).
// CPU side: req/we/byte_en/addr/page/wdata -> rdata/ack/err/busy; SRAM side.
module slc_mem_ctrl
  import slc_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LANES       = lanes_of(DATA_W),
  parameter int CPU_ADDR_W  = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [LANES-1:0]         byte_en,
  input  logic [CPU_ADDR_W-1:0]    addr,
  input  logic [ADDR_W-CPU_ADDR_W-1:0] page,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ack,
  output logic                     err,
  output logic                     busy,
  output logic                     Mem_CE,
  output logic                     Mem_OE,
  output logic                     Mem_WE,
  output logic [LANES-1:0]         Mem_BE,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        Data_out,
  output logic                     Data_oe,
  input  logic [DATA_W-1:0]        Data_in,
  input  logic                     mem_ready
);

  state_e state_q, state_d;
  logic   we_q;
  logic   rel_err;
  logic   t_done, t_to;

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) u_timer (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (state_q == S_SETUP),
    .tick     (state_q == S_STROBE),
    .ready    (mem_ready),
    .done     (t_done),
    .timed_out(t_to)
  );

  always_comb begin
    state_d = state_q;
    rel_err = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (req)
          state_d = (we && byte_en == '0) ? S_RELEASE : S_SETUP;
      S_SETUP:
        state_d = S_STROBE;
      S_STROBE:
        // a late ready wins over a timeout seen in the same cycle
        if (t_done && mem_ready) begin
          state_d = S_RELEASE;
        end else if (t_to) begin
          state_d = S_RELEASE;
          rel_err = 1'b1;
        end
      S_RELEASE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change
  // exactly on the clock edge that enters each state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      ADDR     <= '0;
      Data_out <= '0;
      Data_oe  <= 1'b0;
      Mem_CE   <= STB_OFF;
      Mem_OE   <= STB_OFF;
      Mem_WE   <= STB_OFF;
      Mem_BE   <= {LANES{STB_OFF}};
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      ack     <= (state_d == S_RELEASE);
      err     <= rel_err;

      if (state_q == S_IDLE && req) begin
        we_q     <= we;
        ADDR     <= {page, addr};
        Data_out <= wdata;
      end

      if (state_q == S_STROBE && state_d == S_RELEASE && !we_q)
        rdata <= rel_err ? '1 : Data_in;

      unique case (state_d)
        S_IDLE: begin
          Mem_CE  <= STB_OFF;
          Mem_OE  <= STB_OFF;
          Mem_WE  <= STB_OFF;
          Mem_BE  <= {LANES{STB_OFF}};
          Data_oe <= 1'b0;
        end
        S_SETUP: begin
          Mem_CE  <= STB_ON;
          Mem_OE  <= we ? STB_OFF : STB_ON;
          Mem_WE  <= STB_OFF;
          Mem_BE  <= we ? ~byte_en : '0;
          Data_oe <= we;
        end
        S_STROBE: begin
          Mem_OE <= we_q ? STB_OFF : STB_ON;
          Mem_WE <= we_q ? STB_ON : STB_OFF;
        end
        // CE, BE and Data_oe hold through release for hold time
        S_RELEASE: begin
          Mem_OE <= STB_OFF;
          Mem_WE <= STB_OFF;
        end
        default: begin
          Mem_CE <= STB_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc_mem_ctrl.sv
// tb_slc_mem_ctrl: directed and random checks of slc_mem_ctrl
// against a cycle-index reference model of the SRAM access timing.
module tb_slc_mem_ctrl;

  localparam int DW  = 16;
  localparam int LN  = 2;
  localparam int CAW = 16;
  localparam int AW  = 20;
  localparam int WC  = 2;
  localparam int TO  = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [LN-1:0] byte_en = '0;
  logic [CAW-1:0] addr = '0;
  logic [AW-CAW-1:0] page = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          ack, err, busy;
  logic          Mem_CE, Mem_OE, Mem_WE;
  logic [LN-1:0] Mem_BE;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] Data_out;
  logic          Data_oe;
  logic [DW-1:0] Data_in = '0;
  logic          mem_ready = 1'b1;

  slc_mem_ctrl #(
    .DATA_W(DW), .CPU_ADDR_W(CAW), .ADDR_W(AW),
    .WAIT_CYCLES(WC), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we),
    .byte_en(byte_en), .addr(addr), .page(page),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
    .busy(busy), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE),
    .Mem_WE(Mem_WE), .Mem_BE(Mem_BE), .ADDR(ADDR),
    .Data_out(Data_out), .Data_oe(Data_oe),
    .Data_in(Data_in), .mem_ready(mem_ready)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access. Cycle 0 = req sampled. lowc = mem_ready low cycles
  // once the wait count has run out. keep = hold req high to the end.
  task automatic run_txn(input logic w, input logic [LN-1:0] be,
                         input logic [CAW-1:0] a,
                         input logic [AW-CAW-1:0] pg,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] din,
                         input int lowc, input bit keep,
                         output int ack_cyc);
    int r;
    bit skip, to;
    logic [DW-1:0] rd_new;
    logic [LN-1:0] exp_be;
    skip    = w && (be == '0);
    to      = !skip && (lowc > TO);
    r       = skip ? 1 : WC + 3 + ((lowc < TO) ? lowc : TO);
    rd_new  = w ? m_rdata : (to ? '1 : din);
    exp_be  = w ? ~be : '0;
    ack_cyc = -1;
    for (int k = 0; k <= r; k++) begin
      @(posedge Clk); #1;
      if (k == 0) begin
        req = 1'b1; we = w; byte_en = be;
        addr = a; page = pg; wdata = wd;
      end else begin
        req = keep; we = 1'($urandom);
        byte_en = LN'($urandom); addr = CAW'($urandom);
        page = (AW-CAW)'($urandom); wdata = DW'($urandom);
      end
      if (k >= 1 && k <= WC + 1) mem_ready = 1'($urandom);
      else if (k >= WC + 2 && k < WC + 2 + lowc) mem_ready = 1'b0;
      else mem_ready = 1'b1;
      Data_in = (k == r - 1) ? din : DW'($urandom);
      @(negedge Clk);
      if (k == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_ce", Mem_CE, 1);
        chk("idle_we", Mem_WE, 1);
        chk("idle_doe", Data_oe, 0);
        chk("idle_ack", ack, 0);
      end else begin
        chk("busy", busy, 1);
        chk("ack", ack, k == r);
        chk("err", err, (k == r) && to);
        chk("rdata", rdata, (k == r) ? rd_new : m_rdata);
        if (skip) begin
          chk("skip_ce", Mem_CE, 1);
          chk("skip_we", Mem_WE, 1);
          chk("skip_oe", Mem_OE, 1);
          chk("skip_be", Mem_BE, 2'b11);
          chk("skip_doe", Data_oe, 0);
        end else begin
          chk("ce", Mem_CE, 0);
          chk("addr", ADDR, {pg, a});
          chk("doe", Data_oe, w);
          chk("be", Mem_BE, exp_be);
          chk("we", Mem_WE, (k > 1 && k < r) ? !w : 1'b1);
          chk("oe", Mem_OE, (!w && k < r) ? 1'b0 : 1'b1);
          if (w) chk("dout", Data_out, wd);
        end
      end
      if (k == r) ack_cyc = cyc;
    end
    m_rdata = rd_new;
  endtask

  initial begin
    int c1, c2;
    // reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ce", Mem_CE, 1);
    chk("rst_oe", Mem_OE, 1);
    chk("rst_we", Mem_WE, 1);
    chk("rst_be", Mem_BE, 2'b11);
    chk("rst_doe", Data_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_dout", Data_out, 0);
    @(posedge Clk); #1 Reset = 1'b1;

    // reset in the middle of a write strobe
    @(posedge Clk); #1;
    req = 1'b1; we = 1'b1; byte_en = 2'b11;
    addr = 16'h0042; page = 4'h1; wdata = 16'h1357;
    mem_ready = 1'b1;
    @(posedge Clk); #1 req = 1'b0;
    @(posedge Clk); #1;
    chk("mid_we_low", Mem_WE, 0);
    Reset = 1'b0; #1;
    chk("arst_we", Mem_WE, 1);
    chk("arst_ce", Mem_CE, 1);
    chk("arst_busy", busy, 0);
    chk("arst_doe", Data_oe, 0);
    m_rdata = '0;
    @(posedge Clk); #1 Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("arst_noack", ack, 0);
      chk("arst_idle", busy, 0);
    end

    // directed accesses
    run_txn(1'b0, 2'b11, 16'h1234, 4'h3, 16'h0000, 16'hBEEF, 0, 0, c1);
    chk("rd_addr_full", ADDR, 20'h31234);
    run_txn(1'b1, 2'b10, 16'h0100, 4'h2, 16'hA55A, 16'h0000, 0, 0, c1);
    run_txn(1'b0, 2'b01, 16'h0777, 4'h5, 16'h0000, 16'hC0DE, 3, 0, c1);
    run_txn(1'b0, 2'b11, 16'h0888, 4'h6, 16'h0000, 16'h1111, 30, 0, c1);
    chk("to_rdata", rdata, 16'hFFFF);
    run_txn(1'b1, 2'b00, 16'h0999, 4'h7, 16'h2222, 16'h0000, 0, 0, c1);
    run_txn(1'b0, 2'b11, 16'h0010, 4'h1, 16'h0000, 16'h4321, 0, 1, c1);
    run_txn(1'b0, 2'b11, 16'h0011, 4'h1, 16'h0000, 16'h8765, 0, 0, c2);
    chk("b2b_gap", 32'(c2 - c1), 32'd6);
    run_txn(1'b0, 2'b11, 16'h0020, 4'h2, 16'h0000, 16'h5A5A, TO, 0, c1);
    run_txn(1'b0, 2'b11, 16'h0021, 4'h2, 16'h0000, 16'hA5A5, TO + 1, 0, c1);

    // random accesses
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom), LN'($urandom), CAW'($urandom),
              (AW-CAW)'($urandom), DW'($urandom), DW'($urandom),
              $urandom_range(0, 12), ($urandom_range(0, 3) == 0), c1);
    end

    @(posedge Clk); #1 req = 1'b0;
    @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
